// File: rtl/mem_arbiter_if.sv
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'd0
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'd1
`endif
`ifndef GET_FREE
`define GET_FREE 2'd2
`endif

`default_nettype none

/*----------------------------------------------------------------------------
 * mem_arbiter_if
 * Command/response bus between the arbiter (master) and the memory unit.
 * Rev 1.0
 *--------------------------------------------------------------------------*/
interface mem_arbiter_if;
   logic [1:0]                      mem_func;
   logic                            mem_execute;
   logic [`MEMORY_ADDR_WIDTH-1:0]   mem_address1;
   logic [`MEMORY_ADDR_WIDTH-1:0]   mem_address2;
   logic [`MEMORY_DATA_WIDTH-1:0]   mem_write_data;
   logic                            mem_gc_ready;
   logic                            mem_is_ready;
   logic                            mem_gc;
   logic [`MEMORY_DATA_WIDTH-1:0]   mem_read_data1;
   logic [`MEMORY_DATA_WIDTH-1:0]   mem_read_data2;
   logic [`MEMORY_ADDR_WIDTH-1:0]   mem_free_addr;

   modport master (
      output mem_func, mem_execute, mem_address1, mem_address2, mem_write_data, mem_gc_ready,
      input  mem_is_ready, mem_gc, mem_read_data1, mem_read_data2, mem_free_addr
   );

   modport slave (
      input  mem_func, mem_execute, mem_address1, mem_address2, mem_write_data, mem_gc_ready,
      output mem_is_ready, mem_gc, mem_read_data1, mem_read_data2, mem_free_addr
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
`ifndef GET_FREE
`define GET_FREE 2'd2
`endif

`default_nettype none

/*----------------------------------------------------------------------------
 * mem_arbiter
 * Two-client arbiter for the memory unit with GC hold/drain and GET_FREE re-issue.
 * Rev 1.0
 *--------------------------------------------------------------------------*/
module mem_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  wire                             clk,
   input  wire                             rst,
   input  wire                             c0_req,
   input  wire                             c1_req,
   input  wire [1:0]                       c0_func,
   input  wire [1:0]                       c1_func,
   input  wire [`MEMORY_ADDR_WIDTH-1:0]    c0_addr1,
   input  wire [`MEMORY_ADDR_WIDTH-1:0]    c0_addr2,
   input  wire [`MEMORY_ADDR_WIDTH-1:0]    c1_addr1,
   input  wire [`MEMORY_ADDR_WIDTH-1:0]    c1_addr2,
   input  wire [`MEMORY_DATA_WIDTH-1:0]    c0_wdata,
   input  wire [`MEMORY_DATA_WIDTH-1:0]    c1_wdata,
   output logic                            c0_done,
   output logic                            c1_done,
   output logic [`MEMORY_DATA_WIDTH-1:0]   rdata1,
   output logic [`MEMORY_DATA_WIDTH-1:0]   rdata2,
   output logic [`MEMORY_ADDR_WIDTH-1:0]   faddr,
   output logic                            gc_done,
   output logic [`MEMORY_ADDR_WIDTH-1:0]   gc_root,
   mem_arbiter_if.master                   mem
);

   localparam int         c_AW       = `MEMORY_ADDR_WIDTH;
   localparam int         c_DW       = `MEMORY_DATA_WIDTH;
   localparam logic [1:0] c_GET_FREE = `GET_FREE;

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_ISSUE    = 3'd1;
   localparam logic [2:0] c_WAIT     = 3'd2;
   localparam logic [2:0] c_GC_HOLD  = 3'd3;
   localparam logic [2:0] c_GC_DRAIN = 3'd4;
   localparam logic [2:0] c_DONE     = 3'd5;

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [2:0]      r_gc_ret;
   logic            r_grant;
   logic            r_last;
   logic            r_gc_done;
   logic            w_pick;
   logic            w_grant;
   logic            w_free_gc;
   logic            w_capture;
   logic [1:0]      r_func;
   logic [c_AW-1:0] r_addr1;
   logic [c_AW-1:0] r_addr2;
   logic [c_DW-1:0] r_wdata;
   logic [c_DW-1:0] r_rdata1;
   logic [c_DW-1:0] r_rdata2;
   logic [c_AW-1:0] r_faddr;
   logic [c_AW-1:0] r_gc_root;

   // A GC reported against GET_FREE means the allocation was not served.
   assign w_free_gc = mem.mem_gc && (r_func == c_GET_FREE);
   assign w_capture = (r_state == c_WAIT) && mem.mem_is_ready && !w_free_gc;
   assign w_grant   = (r_state == c_IDLE) && (w_next_state == c_ISSUE);

   always_comb begin
      w_pick = c1_req;
      if (c0_req && c1_req) begin
         w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (mem.mem_gc) begin
               w_next_state = c_GC_HOLD;
            end else if (mem.mem_is_ready && (c0_req || c1_req)) begin
               w_next_state = c_ISSUE;
            end
         end
         c_ISSUE:    w_next_state = c_WAIT;
         c_WAIT: begin
            if (mem.mem_is_ready) begin
               w_next_state = mem.mem_gc ? c_GC_HOLD : c_DONE;
            end
         end
         c_GC_HOLD: begin
            if (!mem.mem_gc) begin
               w_next_state = c_GC_DRAIN;
            end
         end
         c_GC_DRAIN: begin
            if (mem.mem_is_ready) begin
               w_next_state = r_gc_ret;
            end
         end
         c_DONE:     w_next_state = c_IDLE;
         default:    w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_execute  = 1'b0;
      mem.mem_gc_ready = 1'b0;
      c0_done          = 1'b0;
      c1_done          = 1'b0;
      case (r_state)
         c_ISSUE:   mem.mem_execute  = 1'b1;
         c_GC_HOLD: mem.mem_gc_ready = mem.mem_gc;
         c_DONE: begin
            c0_done = ~r_grant;
            c1_done = r_grant;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant   <= 1'b0;
         r_last    <= 1'b1;
         r_gc_ret  <= c_IDLE;
         r_gc_done <= 1'b0;
         r_func    <= '0;
         r_addr1   <= '0;
         r_addr2   <= '0;
         r_wdata   <= '0;
         r_rdata1  <= '0;
         r_rdata2  <= '0;
         r_faddr   <= '0;
         r_gc_root <= '0;
      end else begin
         r_gc_done <= 1'b0;
         if (w_grant) begin
            r_grant <= w_pick;
            r_func  <= w_pick ? c1_func  : c0_func;
            r_addr1 <= w_pick ? c1_addr1 : c0_addr1;
            r_addr2 <= w_pick ? c1_addr2 : c0_addr2;
            r_wdata <= w_pick ? c1_wdata : c0_wdata;
         end
         if (w_capture) begin
            r_rdata1 <= mem.mem_read_data1;
            r_rdata2 <= mem.mem_read_data2;
            r_faddr  <= mem.mem_free_addr;
         end
         // Where to resume once the collection has drained.
         if (w_next_state == c_GC_HOLD) begin
            if (r_state == c_IDLE) begin
               r_gc_ret <= c_IDLE;
            end else if (r_state == c_WAIT) begin
               r_gc_ret <= w_free_gc ? c_ISSUE : c_DONE;
            end
         end
         if ((r_state == c_GC_DRAIN) && mem.mem_is_ready) begin
            r_gc_root <= mem.mem_read_data1[c_AW-1:0];
            r_gc_done <= 1'b1;
         end
         if (r_state == c_DONE) begin
            r_last <= r_grant;
         end
      end
   end

   assign mem.mem_func       = r_func;
   assign mem.mem_address1   = r_addr1;
   assign mem.mem_address2   = r_addr2;
   assign mem.mem_write_data = r_wdata;
   assign rdata1             = r_rdata1;
   assign rdata2             = r_rdata2;
   assign faddr              = r_faddr;
   assign gc_root            = r_gc_root;
   assign gc_done            = r_gc_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'd0
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'd1
`endif
`ifndef GET_FREE
`define GET_FREE 2'd2
`endif

`default_nettype none

/*----------------------------------------------------------------------------
 * tb_mem_arbiter
 * Scoreboard bench: behavioural memory unit, round-robin DUT plus fixed-priority twin.
 * Rev 1.0
 *--------------------------------------------------------------------------*/
module tb_mem_arbiter;

   localparam int         AW     = `MEMORY_ADDR_WIDTH;
   localparam int         DW     = `MEMORY_DATA_WIDTH;
   localparam logic [1:0] F_GET  = `GET_CONTENTS;
   localparam logic [1:0] F_SET  = `SET_CONTENTS;
   localparam logic [1:0] F_FREE = `GET_FREE;
   localparam int         LAT    = 2;
   localparam logic [AW-1:0] GC_ROOT     = 11'h123;
   localparam logic [AW-1:0] POST_GC_PTR = 11'h040;
   localparam int M_IDLE = 0, M_BUSY = 1, M_GCWAIT = 2, M_GC = 3, M_DRAIN = 4;

   typedef struct packed {
      logic          port;
      logic          chk;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic          chkf;
      logic [AW-1:0] fa;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          c0_req, c1_req;
   logic [1:0]    c0_func, c1_func;
   logic [AW-1:0] c0_addr1, c0_addr2, c1_addr1, c1_addr2;
   logic [DW-1:0] c0_wdata, c1_wdata;
   logic          c0_done, c1_done, gc_done;
   logic [DW-1:0] rdata1, rdata2;
   logic [AW-1:0] faddr, gc_root;
   logic          p_c0_done, p_c1_done, p_gc_done;
   logic [DW-1:0] p_rdata1, p_rdata2;
   logic [AW-1:0] p_faddr, p_gc_root;

   logic          m_ready, m_gc, hold_busy, m_full;
   logic [DW-1:0] m_rd1, m_rd2, m_wd;
   logic [AW-1:0] m_faddr, m_free_ptr, m_a1, m_a2;
   logic [1:0]    m_func;
   logic [DW-1:0] mem_arr [0:(1<<AW)-1];
   int            m_st, m_cnt, exec_cnt, gc_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   gc_seen = 0;
   int   p_c0_cnt = 0;
   int   p_c1_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   mem_arbiter_if mem_bus ();
   mem_arbiter_if mem_bus_p ();

   assign mem_bus.mem_is_ready   = m_ready;
   assign mem_bus.mem_gc         = m_gc;
   assign mem_bus.mem_read_data1 = m_rd1;
   assign mem_bus.mem_read_data2 = m_rd2;
   assign mem_bus.mem_free_addr  = m_faddr;
   assign mem_bus_p.mem_is_ready   = m_ready;
   assign mem_bus_p.mem_gc         = m_gc;
   assign mem_bus_p.mem_read_data1 = m_rd1;
   assign mem_bus_p.mem_read_data2 = m_rd2;
   assign mem_bus_p.mem_free_addr  = m_faddr;

   mem_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c1_req(c1_req), .c0_func(c0_func), .c1_func(c1_func),
      .c0_addr1(c0_addr1), .c0_addr2(c0_addr2), .c1_addr1(c1_addr1), .c1_addr2(c1_addr2),
      .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c0_done(c0_done), .c1_done(c1_done),
      .rdata1(rdata1), .rdata2(rdata2), .faddr(faddr), .gc_done(gc_done), .gc_root(gc_root),
      .mem(mem_bus)
   );

   // Fixed-priority twin shares every input; it only differs on ties.
   mem_arbiter #(.FIXED_PRIO(1)) dut_fixed (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c1_req(c1_req), .c0_func(c0_func), .c1_func(c1_func),
      .c0_addr1(c0_addr1), .c0_addr2(c0_addr2), .c1_addr1(c1_addr1), .c1_addr2(c1_addr2),
      .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c0_done(p_c0_done), .c1_done(p_c1_done),
      .rdata1(p_rdata1), .rdata2(p_rdata2), .faddr(p_faddr), .gc_done(p_gc_done), .gc_root(p_gc_root),
      .mem(mem_bus_p)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_op(input logic port, input logic chk, input logic [DW-1:0] r1,
                            input logic [DW-1:0] r2, input logic chkf, input logic [AW-1:0] fa);
      exp_t e;
      e.port = port; e.chk = chk; e.rd1 = r1; e.rd2 = r2; e.chkf = chkf; e.fa = fa;
      sb_q.push_back(e);
   endtask

   task automatic issue(input int port, input logic [1:0] f, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] wd);
      if (port == 0) begin
         c0_func = f; c0_addr1 = a1; c0_addr2 = a2; c0_wdata = wd; c0_req = 1'b1;
      end else begin
         c1_func = f; c1_addr1 = a1; c1_addr2 = a2; c1_wdata = wd; c1_req = 1'b1;
      end
   endtask

   task automatic wait_done(input int port, input int max_cyc);
      int   n = 0;
      logic seen = 1'b0;
      while (!seen && n < max_cyc) begin
         @(negedge clk);
         n++;
         seen = (port == 0) ? c0_done : c1_done;
      end
      check_val("done_seen", {63'd0, seen}, 64'd1);
      if (port == 0) c0_req = 1'b0; else c1_req = 1'b0;
   endtask

   task automatic check_rst_state(input string where);
      check_val({where, "_ctl"}, {c0_done, c1_done, gc_done, mem_bus.mem_execute, mem_bus.mem_gc_ready}, 64'd0);
      check_val({where, "_cmd"}, {mem_bus.mem_func, mem_bus.mem_address1, mem_bus.mem_address2,
                                  mem_bus.mem_write_data}, 64'd0);
      check_val({where, "_res"}, {rdata1, rdata2, faddr, gc_root}, 64'd0);
      check_val({where, "_fix"}, {p_c0_done, p_c1_done, p_gc_done, mem_bus_p.mem_execute,
                                  mem_bus_p.mem_gc_ready, p_rdata1 | p_rdata2 | mem_bus_p.mem_write_data,
                                  p_faddr | p_gc_root | mem_bus_p.mem_address1 | mem_bus_p.mem_address2,
                                  mem_bus_p.mem_func}, 64'd0);
   endtask

   // Behavioural memory unit: LAT-cycle ops, GC handshake when an allocation finds memory full.
   initial begin
      m_ready = 1'b1; m_gc = 1'b0; m_rd1 = '0; m_rd2 = '0; m_faddr = '0; m_wd = '0;
      m_a1 = '0; m_a2 = '0; m_func = '0; m_st = M_IDLE; m_cnt = 0;
      m_free_ptr = 11'h100; exec_cnt = 0; gc_cnt = 0;
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 16'hA000 | 16'(i);
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            m_st = M_IDLE; m_gc = 1'b0; m_ready = !hold_busy;
         end else begin
            if (m_st != M_IDLE && mem_bus.mem_execute) check_val("exec_while_busy", 64'(mem_bus.mem_execute), 64'd0);
            case (m_st)
               M_IDLE: begin
                  m_ready = !hold_busy;
                  if (mem_bus.mem_execute) begin
                     exec_cnt++;
                     m_func = mem_bus.mem_func; m_a1 = mem_bus.mem_address1;
                     m_a2 = mem_bus.mem_address2; m_wd = mem_bus.mem_write_data;
                     m_ready = 1'b0; m_cnt = LAT; m_st = M_BUSY;
                  end
               end
               M_BUSY: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     m_ready = 1'b1; m_st = M_IDLE;
                     if (m_func == F_GET) begin
                        m_rd1 = mem_arr[m_a1]; m_rd2 = mem_arr[m_a2];
                     end else if (m_func == F_SET) begin
                        mem_arr[m_a1] = m_wd;
                     end else if (m_func == F_FREE) begin
                        if (m_full) begin
                           m_gc = 1'b1; m_st = M_GCWAIT;
                        end else begin
                           m_faddr = m_free_ptr; m_free_ptr = m_free_ptr + m_wd[AW-1:0];
                        end
                     end
                  end
               end
               M_GCWAIT: begin
                  if (mem_bus.mem_gc_ready) begin
                     m_ready = 1'b0; m_cnt = 3; m_st = M_GC;
                  end
               end
               M_GC: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     m_gc = 1'b0; m_cnt = 2; m_st = M_DRAIN;
                  end
               end
               M_DRAIN: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     m_ready = 1'b1; m_rd1 = {{(DW-AW){1'b1}}, GC_ROOT};
                     m_full = 1'b0; m_free_ptr = POST_GC_PTR; gc_cnt++; m_st = M_IDLE;
                  end
               end
               default: m_st = M_IDLE;
            endcase
         end
      end
   end

   // Completion monitor: pops the scoreboard on every done strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (c0_done && c1_done) check_val("both_done", 64'd1, 64'd0);
         if (c0_done || c1_done) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_done", {c1_done, c0_done}, 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("done_port", 64'(c1_done), 64'(mon_e.port));
               if (mon_e.chk) begin
                  check_val("rdata1", 64'(rdata1), 64'(mon_e.rd1));
                  check_val("rdata2", 64'(rdata2), 64'(mon_e.rd2));
               end
               if (mon_e.chkf) check_val("faddr", 64'(faddr), 64'(mon_e.fa));
            end
         end
         if (gc_done) begin
            gc_seen++;
            check_val("gc_root", 64'(gc_root), 64'(GC_ROOT));
         end
         if (p_c0_done) p_c0_cnt++;
         if (p_c1_done) p_c1_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, g0, gm0, n, ndone;
      rst = 1'b0; hold_busy = 1'b1; m_full = 1'b0;
      c0_req = 1'b0; c1_req = 1'b0; c0_func = '0; c1_func = '0;
      c0_addr1 = '0; c0_addr2 = '0; c1_addr1 = '0; c1_addr2 = '0; c0_wdata = '0; c1_wdata = '0;
      repeat (3) @(negedge clk);
      check_rst_state("rst_init");
      rst = 1'b1;

      // No grant while the memory reports busy.
      e0 = exec_cnt;
      issue(0, F_GET, 11'h005, 11'h006, '0);
      repeat (6) @(negedge clk);
      check_val("busy_no_exec", 64'(exec_cnt - e0), 64'd0);
      expect_op(1'b0, 1'b1, 16'hA005, 16'hA006, 1'b0, '0);
      hold_busy = 1'b0;
      wait_done(0, 50);
      check_val("get_exec_once", 64'(exec_cnt - e0), 64'd1);

      issue(1, F_SET, 11'h010, 11'h000, 16'h1234);
      expect_op(1'b1, 1'b0, '0, '0, 1'b0, '0);
      wait_done(1, 50);
      issue(0, F_GET, 11'h010, 11'h011, '0);
      expect_op(1'b0, 1'b1, 16'h1234, 16'hA011, 1'b0, '0);
      wait_done(0, 50);

      // Allocation against full memory: GC, then exactly one re-issue.
      m_full = 1'b1; e0 = exec_cnt; g0 = gc_seen; gm0 = gc_cnt;
      issue(0, F_FREE, '0, '0, 16'd3);
      expect_op(1'b0, 1'b0, '0, '0, 1'b1, POST_GC_PTR);
      wait_done(0, 100);
      check_val("gc_exec_count", 64'(exec_cnt - e0), 64'd2);
      check_val("gc_done_pulses", 64'(gc_seen - g0), 64'd1);
      check_val("gc_cycles", 64'(gc_cnt - gm0), 64'd1);
      issue(1, F_FREE, '0, '0, 16'd2);
      expect_op(1'b1, 1'b0, '0, '0, 1'b1, 11'h043);
      wait_done(1, 50);

      // Request dropped after grant still completes.
      issue(1, F_GET, 11'h007, 11'h008, '0);
      expect_op(1'b1, 1'b1, 16'hA007, 16'hA008, 1'b0, '0);
      repeat (2) @(negedge clk);
      c1_req = 1'b0;
      wait_done(1, 50);

      // Held simultaneous requests from a fresh pointer.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; p_c0_cnt = 0; p_c1_cnt = 0;
      expect_op(1'b0, 1'b1, 16'hA001, 16'hA002, 1'b0, '0);
      expect_op(1'b1, 1'b1, 16'hA003, 16'hA004, 1'b0, '0);
      expect_op(1'b0, 1'b1, 16'hA001, 16'hA002, 1'b0, '0);
      expect_op(1'b1, 1'b1, 16'hA003, 16'hA004, 1'b0, '0);
      issue(0, F_GET, 11'h001, 11'h002, '0);
      issue(1, F_GET, 11'h003, 11'h004, '0);
      ndone = 0; n = 0;
      while (ndone < 4 && n < 300) begin
         @(negedge clk);
         n++;
         if (c0_done || c1_done) ndone++;
      end
      c0_req = 1'b0; c1_req = 1'b0;
      check_val("tie_done_count", 64'(ndone), 64'd4);
      @(negedge clk);
      check_val("fixed_c0_grants", 64'(p_c0_cnt), 64'd4);
      check_val("fixed_c1_grants", 64'(p_c1_cnt), 64'd0);
      repeat (3) @(negedge clk);

      // Reset in WAIT: op is abandoned, no done.
      e0 = exec_cnt; n = 0;
      issue(0, F_GET, 11'h009, 11'h009, '0);
      while (exec_cnt == e0 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check_val("wait_exec", 64'(exec_cnt - e0), 64'd1);
      @(negedge clk); #1;
      rst = 1'b0; c0_req = 1'b0;
      @(negedge clk); #1;
      check_rst_state("rst_wait");
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);

      // Reset in GC_HOLD.
      m_full = 1'b1; n = 0;
      issue(0, F_FREE, '0, '0, 16'd1);
      while (mem_bus.mem_gc_ready !== 1'b1 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check_val("gc_hold_seen", 64'(mem_bus.mem_gc_ready), 64'd1);
      rst = 1'b0; c0_req = 1'b0;
      @(negedge clk); #1;
      check_rst_state("rst_gc");
      @(negedge clk);
      rst = 1'b1; m_full = 1'b0;
      repeat (8) @(negedge clk);

      check_val("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
